ula_seq_unit: RTL and testbench

ULA_SEQ_UNIT -- requirements
Module: ula_seq_unit

---
 rtl/ula_pkg.sv | 25 ++
 rtl/ula_div_seq.sv | 44 ++++
 rtl/ula_seq_unit.sv | 140 ++++++++++++++
 tb/tb_ula_seq_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// ula_pkg: opcodes, FSM state encoding and result-width helper shared by the ULA sequencer.
package ula_pkg;
    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_MUL   = 4'h2;
    localparam logic [3:0] OP_DIV   = 4'h3;
    localparam logic [3:0] OP_PASSA = 4'h4;
    localparam logic [3:0] OP_PASSB = 4'h5;
    localparam logic [3:0] OP_INC   = 4'h6;
    localparam logic [3:0] OP_DEC   = 4'h7;
    localparam logic [3:0] OP_INC2  = 4'h8;
    localparam logic [3:0] OP_EQ    = 4'h9;
    localparam logic [3:0] OP_LT    = 4'hA;
    localparam logic [3:0] OP_GT    = 4'hB;
    localparam logic [3:0] OP_NOTA  = 4'hC;
    localparam logic [3:0] OP_AND   = 4'hD;
    localparam logic [3:0] OP_OR    = 4'hE;
    localparam logic [3:0] OP_XOR   = 4'hF;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DIV, S_DONE} state_t;

    function automatic int ula_out_w(input int n);
        return 2 * n;
    endfunction
endpackage

// File: rtl/ula_div_seq.sv
// ula_div_seq: restoring divider, one quotient bit per cycle; done pulses one cycle after the last step.
module ula_div_seq #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder
);
    localparam int CW = $clog2(N + 1);
    logic [N-1:0]  dvs;
    logic [CW-1:0] cnt;
    logic [N:0]    trial;

    // quotient doubles as the dividend shift register; freed bits collect quotient bits
    assign trial = {remainder, quotient[N-1]} - {1'b0, dvs};

    always_ff @(posedge clk) begin
        if (rst) begin
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dvs       <= '0;
            cnt       <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                quotient  <= dividend;
                remainder <= '0;
                dvs       <= divisor;
                cnt       <= CW'(N);
            end else if (cnt != '0) begin
                cnt       <= cnt - CW'(1);
                done      <= cnt == CW'(1);
                remainder <= trial[N] ? {remainder[N-2:0], quotient[N-1]} : trial[N-1:0];
                quotient  <= {quotient[N-2:0], ~trial[N]};
            end
        end
    end
endmodule

// File: rtl/ula_seq_unit.sv
// ula_seq_unit: sequenced ULA with start/busy/done handshake and registered result/flags.
// Define ULA_DIV_EN to build the multi-cycle divider; otherwise opcode 0011 reports an error.
module ula_seq_unit
    import ula_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 START,
    input  logic [3:0]                           SEL_ULA,
    input  logic [DATA_WIDTH-1:0]                OP_A,
    input  logic [DATA_WIDTH-1:0]                OP_B,
    output logic                                 BUSY,
    output logic                                 DONE,
    output logic [ula_out_w(DATA_WIDTH)-1:0]     ULA_OUT,
    output logic                                 REG_COMP_OUT,
    output logic                                 REG_OVERFLOW_OUT,
    output logic                                 REG_ERR_OUT
);
    localparam int N  = DATA_WIDTH;
    localparam int OW = ula_out_w(DATA_WIDTH);

    state_t       state;
    logic [N-1:0] a_r, b_r, hi, lo, diff, dec;
    logic [3:0]   op_r;
    logic [N:0]   sum, inc1, inc2;
    logic [OW-1:0] prod;
    logic         ovf, comp, err, go_div;

    assign sum  = {1'b0, b_r} + {1'b0, a_r};
    assign inc1 = {1'b0, b_r} + (N+1)'(1);
    assign inc2 = {1'b0, b_r} + (N+1)'(2);
    assign diff = b_r - a_r;
    assign dec  = b_r - N'(1);
    assign prod = b_r * a_r;

`ifdef ULA_DIV_EN
    logic         div_done;
    logic [N-1:0] div_quo, div_rem;

    // zero divisor never reaches the divider; it completes through EXEC instead
    assign go_div = SEL_ULA == OP_DIV && |OP_A;

    ula_div_seq #(.N(N)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (START && (state == S_IDLE || state == S_DONE) && go_div),
        .dividend (OP_B),
        .divisor  (OP_A),
        .done     (div_done),
        .quotient (div_quo),
        .remainder(div_rem)
    );
`else
    assign go_div = 1'b0;
`endif

    always_comb begin
        hi   = '0;
        lo   = '0;
        ovf  = 1'b0;
        comp = 1'b0;
        err  = 1'b0;
        case (op_r)
            OP_ADD:   begin lo = sum[N-1:0]; hi = N'(sum[N]); ovf = sum[N]; end
            OP_SUB:   begin lo = diff; ovf = b_r < a_r; end
            OP_MUL:   begin {hi, lo} = prod; ovf = |prod[OW-1:N]; end
`ifdef ULA_DIV_EN
            OP_DIV:   begin hi = b_r; lo = '1; err = 1'b1; end
`else
            OP_DIV:   err = 1'b1;
`endif
            OP_PASSA: lo = a_r;
            OP_PASSB: lo = b_r;
            OP_INC:   begin lo = inc1[N-1:0]; ovf = inc1[N]; end
            OP_DEC:   begin lo = dec; ovf = b_r == '0; end
            OP_INC2:  begin lo = inc2[N-1:0]; ovf = inc2[N]; end
            OP_EQ:    begin comp = b_r == a_r; lo = N'(comp); end
            OP_LT:    begin comp = b_r < a_r; lo = N'(comp); end
            OP_GT:    begin comp = b_r > a_r; lo = N'(comp); end
            OP_NOTA:  lo = ~a_r;
            OP_AND:   lo = b_r & a_r;
            OP_OR:    lo = b_r | a_r;
            OP_XOR:   lo = b_r ^ a_r;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            BUSY             <= 1'b0;
            DONE             <= 1'b0;
            ULA_OUT          <= '0;
            REG_COMP_OUT     <= 1'b0;
            REG_OVERFLOW_OUT <= 1'b0;
            REG_ERR_OUT      <= 1'b0;
            a_r              <= '0;
            b_r              <= '0;
            op_r             <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    state <= START ? (go_div ? S_DIV : S_EXEC) : S_IDLE;
                    BUSY  <= START;
                    if (START) begin
                        a_r  <= OP_A;
                        b_r  <= OP_B;
                        op_r <= SEL_ULA;
                    end
                end
                S_EXEC: begin
                    state            <= S_DONE;
                    BUSY             <= 1'b0;
                    DONE             <= 1'b1;
                    ULA_OUT          <= {hi, lo};
                    REG_COMP_OUT     <= comp;
                    REG_OVERFLOW_OUT <= ovf;
                    REG_ERR_OUT      <= err;
                end
`ifdef ULA_DIV_EN
                S_DIV: if (div_done) begin
                    state            <= S_DONE;
                    BUSY             <= 1'b0;
                    DONE             <= 1'b1;
                    ULA_OUT          <= {div_rem, div_quo};
                    REG_COMP_OUT     <= 1'b0;
                    REG_OVERFLOW_OUT <= 1'b0;
                    REG_ERR_OUT      <= 1'b0;
                end
`endif
                default: begin
                    state <= S_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ula_seq_unit.sv
// tb_ula_seq_unit: directed vectors, a latency/result reference model checked every cycle, plus literal checks.
module tb_ula_seq_unit;
    localparam int N = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, START;
    logic [3:0]     SEL_ULA;
    logic [N-1:0]   OP_A, OP_B;
    logic           BUSY, DONE, REG_COMP_OUT, REG_OVERFLOW_OUT, REG_ERR_OUT;
    logic [2*N-1:0] ULA_OUT;

    int n_checks = 0;
    int n_errors = 0;

    ula_seq_unit #(.DATA_WIDTH(N)) dut (
        .clk             (clk),
        .rst             (rst),
        .START           (START),
        .SEL_ULA         (SEL_ULA),
        .OP_A            (OP_A),
        .OP_B            (OP_B),
        .BUSY            (BUSY),
        .DONE            (DONE),
        .ULA_OUT         (ULA_OUT),
        .REG_COMP_OUT    (REG_COMP_OUT),
        .REG_OVERFLOW_OUT(REG_OVERFLOW_OUT),
        .REG_ERR_OUT     (REG_ERR_OUT)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // returns {err, comp, ovf, result[15:0]} from plain integer arithmetic
    function automatic logic [18:0] ref_op(input logic [3:0] op, input int a, input int b);
        int r;
        logic o, c, e;
        r = 0; o = 1'b0; c = 1'b0; e = 1'b0;
        case (op)
            4'h0: begin r = b + a; o = r > 255; end
            4'h1: begin r = (b - a) & 255; o = b < a; end
            4'h2: begin r = b * a; o = r > 255; end
            4'h3: begin
                e = (a == 0);
`ifdef ULA_DIV_EN
                r = (a == 0) ? ((b << 8) | 255) : (((b % a) << 8) | (b / a));
`else
                e = 1'b1;
`endif
            end
            4'h4: r = a;
            4'h5: r = b;
            4'h6: begin r = (b + 1) & 255; o = b == 255; end
            4'h7: begin r = (b - 1) & 255; o = b == 0; end
            4'h8: begin r = (b + 2) & 255; o = b >= 254; end
            4'h9: begin c = b == a; r = int'(c); end
            4'hA: begin c = b < a; r = int'(c); end
            4'hB: begin c = b > a; r = int'(c); end
            4'hC: r = (~a) & 255;
            4'hD: r = b & a;
            4'hE: r = b | a;
            default: r = b ^ a;
        endcase
        return {e, c, o, 16'(r)};
    endfunction

    function automatic int lat(input logic [3:0] op, input int a);
`ifdef ULA_DIV_EN
        return (op == 4'h3 && a != 0) ? N + 1 : 1;
`else
        return 1;
`endif
    endfunction

    // model: one operation in flight, completing a fixed number of edges after acceptance
    logic        m_valid = 1'b0;
    logic        m_busy, m_done, m_ovf, m_comp, m_err, p_ovf, p_comp, p_err;
    logic [15:0] m_out, p_out;
    int          m_left;

    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b1;
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_out   <= '0;
            m_ovf   <= 1'b0;
            m_comp  <= 1'b0;
            m_err   <= 1'b0;
            m_left  <= 0;
        end else if (m_valid) begin
            m_done <= 1'b0;
            if (m_busy) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_out  <= p_out;
                    m_ovf  <= p_ovf;
                    m_comp <= p_comp;
                    m_err  <= p_err;
                end
            end else if (START) begin
                {p_err, p_comp, p_ovf, p_out} <= ref_op(SEL_ULA, int'(OP_A), int'(OP_B));
                m_left <= lat(SEL_ULA, int'(OP_A));
                m_busy <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy", 32'(BUSY), 32'(m_busy));
            chk("done", 32'(DONE), 32'(m_done));
            chk("ula_out", 32'(ULA_OUT), 32'(m_out));
            chk("overflow", 32'(REG_OVERFLOW_OUT), 32'(m_ovf));
            chk("comp", 32'(REG_COMP_OUT), 32'(m_comp));
            chk("err", 32'(REG_ERR_OUT), 32'(m_err));
        end
    end

    // call at a negedge; START is high for exactly one rising edge
    task automatic start_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        START = 1'b1; SEL_ULA = op; OP_A = a; OP_B = b;
        @(negedge clk);
        START = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!DONE && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", 32'(DONE), 32'd1);
    endtask

    logic [7:0] pa [3] = '{8'h3C, 8'h00, 8'hFF};
    logic [7:0] pb [3] = '{8'hA5, 8'h00, 8'hFE};

    initial begin
        int c;
        rst = 1'b1; START = 1'b0; SEL_ULA = '0; OP_A = '0; OP_B = '0;
        repeat (2) @(negedge clk);
        chk("rst_out", 32'(ULA_OUT), 32'h0);
        chk("rst_busy", 32'(BUSY), 32'h0);
        chk("rst_done", 32'(DONE), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        start_op(4'h0, 8'h01, 8'hFF);
        wait_done(c);
        chk("add_lat", 32'(c), 32'd1);
        chk("add_out", 32'(ULA_OUT), 32'h0100);
        chk("add_ovf", 32'(REG_OVERFLOW_OUT), 32'd1);
        @(negedge clk);
        chk("add_done_width", 32'(DONE), 32'd0);

        start_op(4'h3, 8'd7, 8'd200);
        c = 0;
        while (!DONE && c < 40) begin
            START = (c == 2 || c == 5); SEL_ULA = 4'h0; OP_A = 8'h01; OP_B = 8'h01;
            @(negedge clk);
            c++;
        end
        START = 1'b0;
`ifdef ULA_DIV_EN
        chk("div_lat", 32'(c), 32'd9);
        chk("div_out", 32'(ULA_OUT), 32'h041C);
        chk("div_err", 32'(REG_ERR_OUT), 32'd0);
`else
        chk("div_lat", 32'(c), 32'd1);
        chk("div_out", 32'(ULA_OUT), 32'h0000);
        chk("div_err", 32'(REG_ERR_OUT), 32'd1);
`endif
        @(negedge clk);

        start_op(4'h3, 8'h00, 8'h55);
        wait_done(c);
        chk("div0_lat", 32'(c), 32'd1);
`ifdef ULA_DIV_EN
        chk("div0_out", 32'(ULA_OUT), 32'h55FF);
`else
        chk("div0_out", 32'(ULA_OUT), 32'h0000);
`endif
        chk("div0_err", 32'(REG_ERR_OUT), 32'd1);
        @(negedge clk);

        start_op(4'hA, 8'd5, 8'd3);
        wait_done(c);
        chk("lt_comp", 32'(REG_COMP_OUT), 32'd1);
        chk("lt_out", 32'(ULA_OUT), 32'h0001);
        @(negedge clk);
        start_op(4'h1, 8'd5, 8'd3);
        wait_done(c);
        chk("sub_out", 32'(ULA_OUT), 32'h00FE);
        chk("sub_ovf", 32'(REG_OVERFLOW_OUT), 32'd1);
        chk("sub_comp", 32'(REG_COMP_OUT), 32'd0);
        @(negedge clk);

        start_op(4'h8, 8'h00, 8'hFF);
        wait_done(c);
        chk("plus2_out", 32'(ULA_OUT), 32'h0001);
        chk("plus2_ovf", 32'(REG_OVERFLOW_OUT), 32'd1);
        start_op(4'h7, 8'h00, 8'h00);
        wait_done(c);
        chk("less1_out", 32'(ULA_OUT), 32'h00FF);
        chk("less1_ovf", 32'(REG_OVERFLOW_OUT), 32'd1);
        start_op(4'hC, 8'h0F, 8'h00);
        wait_done(c);
        chk("not_out", 32'(ULA_OUT), 32'h00F0);
        chk("not_ovf", 32'(REG_OVERFLOW_OUT), 32'd0);
        start_op(4'h2, 8'h10, 8'h10);
        wait_done(c);
        chk("mul_out", 32'(ULA_OUT), 32'h0100);
        chk("mul_ovf", 32'(REG_OVERFLOW_OUT), 32'd1);

        for (int i = 0; i < 3; i++)
            for (int op = 0; op < 16; op++) begin
                start_op(4'(op), pa[i], pb[i]);
                wait_done(c);
            end
        @(negedge clk);

        start_op(4'h3, 8'd7, 8'd200);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_out", 32'(ULA_OUT), 32'h0);
        chk("rst_mid_busy", 32'(BUSY), 32'h0);
        chk("rst_mid_done", 32'(DONE), 32'h0);
        rst = 1'b0;
        start_op(4'h0, 8'd2, 8'd3);
        wait_done(c);
        chk("post_rst_lat", 32'(c), 32'd1);
        chk("post_rst_out", 32'(ULA_OUT), 32'h0005);
        @(negedge clk);

        START = 1'b1; SEL_ULA = 4'h0; OP_A = 8'd1; OP_B = 8'd2;
        @(negedge clk);
        wait_done(c);
        chk("b2b_lat1", 32'(c), 32'd1);
        chk("b2b_out1", 32'(ULA_OUT), 32'h0003);
        SEL_ULA = 4'h2; OP_A = 8'h10; OP_B = 8'h10;
        @(negedge clk);
        START = 1'b0;
        chk("b2b_busy", 32'(BUSY), 32'd1);
        chk("b2b_gap", 32'(DONE), 32'd0);
        @(negedge clk);
        chk("b2b_done2", 32'(DONE), 32'd1);
        chk("b2b_out2", 32'(ULA_OUT), 32'h0100);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
